pipe_result_collector: RTL and testbench
========================================

# pipe_result_collector

Consumer-end companion of the selectable pipeline register in the FC datapath. It issues operands into an external delay line of `num_of_pipes` stages, or into its bypass path, using a ready/valid handshake. It tracks the in-flight slots and captures the words leaving the delay line into a small FIFO. Downstream logic drains that FIFO through a ready/valid output. Issue credit ensures no result is ever dropped.

## Interface
Parameters:
- `num_of_pipes`, default 3: depth of the external delay line; must be ≥ 1.
- `num_of_bits`, default 27: datapath word width.
- `fifo_depth`, default 8: result FIFO entries; must be ≥ 2.

Ports:
- `clk_pll`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  mode select. 1 = delayed (latency `num_of_pipes`), 0 = bypass (latency 0). Must equal the `enable` of the external delay line.
- `issue_valid`  in  1  upstream offers one operand this cycle.
- `issue_ready`  out  1  credit available; an issue is accepted when `issue_valid & issue_ready`.
- `pipe_data`  in  `num_of_bits`  word emerging from the external delay line output.
- `out_data`  out  `num_of_bits`  FIFO head word.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  downstream accepts the head word.
- `in_flight`  out  `$clog2(num_of_pipes+1)`  count of accepted issues not yet captured.
- `mode_err`  out  1  sticky; `enable` changed while `in_flight != 0`.

## Operation
- **Tracker:** a valid-bit shift register `trk[num_of_pipes-1:0]`.
  - Each cycle `trk[0] <= accept & enable`, and `trk[i] <= trk[i-1]`.
  - Capture strobe `cap = enable ? trk[num_of_pipes-1] : accept`.
  - `in_flight` is the population count of `trk`; it is always 0 in bypass.
- **Capture:** when `cap` is high, `pipe_data` is written into the FIFO at `wr_ptr` on that edge.
- **Pop:** when `out_valid & out_ready`, `rd_ptr` advances.
- **Pointers:** wrap from `fifo_depth-1` to 0; `fifo_depth` need not be a power of two.
- **Count:** `count` has width `$clog2(fifo_depth+1)`. It is incremented on capture only, decremented on pop only, and unchanged on simultaneous capture and pop.
- **Credit:** `issue_ready = !reset && (count + in_flight) < fifo_depth`.
  - This is conservative: a same-cycle pop does not add credit.
  - It guarantees capture never occurs while the FIFO is full.
- **Mode change:** `enable_q` is the registered `enable`. If `enable != enable_q` and `in_flight != 0`:
  - `mode_err` is set;
  - `trk` is cleared, so those results are discarded;
  - issues accepted in that same cycle follow the new mode.
  - A mode change with `in_flight == 0` is legal and silent.
- **Defensive full write:** if a capture occurs while `count == fifo_depth`, which is unreachable in legal use, the write is suppressed and `mode_err` is set.
- **Output:** `out_data` is the registered FIFO head. It holds its value while `out_valid & !out_ready` and is 0 when empty.

## Timing
- **Reset values:** `issue_ready` 0 while `reset` is high, `out_valid` 0, `out_data` 0, `in_flight` 0, `mode_err` 0. Pointers, `count`, `trk` and `enable_q` are all cleared. Reset mid-operation discards all in-flight and stored words.
- **Delayed mode:** issue accepted at cycle t → `pipe_data` is captured at the edge ending cycle t+`num_of_pipes` → `out_valid` is high from cycle t+`num_of_pipes`+1.
- **Bypass mode:** issue accepted at cycle t → capture at the edge ending cycle t → `out_valid` is high from cycle t+1.
- **Throughput:** one issue and one pop per cycle sustained when the FIFO is neither full nor empty.
- **Pop timing:** a pop at cycle t presents the next head at cycle t+1. It frees credit visible at cycle t+1.
- **Combinational paths:** `issue_ready` depends on registered state and `reset` only. There is no path from `issue_valid` or `out_ready` to `issue_ready`.

## Structure
- Shared constants header: mode encodings `MODE_BYPASS = 0` and `MODE_PIPED = 1`, plus the default widths.
- Sub-module `result_fifo`: parameterised circular buffer with `wr_en`, `rd_en`, `count`, and a registered head.
- The tracker, credit logic and mode checking stay in the top module.

## Test plan
1. **Delayed single issue:** `num_of_pipes=3`, `enable=1`, one issue at cycle 10 with the pipe model returning `27'h1234567` at cycle 13 → `out_valid` high at cycle 14 with `out_data=27'h1234567`; `in_flight` reads 1, 1, 1 during cycles 11–13.
2. **Backpressure to full:** `fifo_depth=8`, `out_ready=0`, `issue_valid` held high → exactly 8 issues accepted; `issue_ready` low from the cycle `count+in_flight` reaches 8; `count` settles at 8 with no loss; then `out_ready=1` drains values 0–7 in order.
3. **Bypass streaming:** `enable=0`, 20 back-to-back issues with `out_ready=1` → `out_valid` from cycle t+1; one word per cycle; `in_flight` stays 0.
4. **Illegal mode change:** `enable` toggles 1→0 with `in_flight=2` → `mode_err` rises the next cycle and stays high; the 2 words are never captured; a subsequent bypass issue flows normally.
5. **Mid-operation reset:** `reset` pulsed for 1 cycle with 3 words stored and 2 in flight → next cycle `out_valid=0`, `in_flight=0`, `mode_err=0`; `issue_ready=1` the cycle after `reset` falls.
6. **Simultaneous capture and pop:** `count=4` when a capture and a pop occur together → `count` stays 4 and data order is preserved.

Source files
------------

// File: rtl/pipe_result_collector_pkg.sv
// Shared constants for the FC datapath result collector: mode encodings,
// default widths and a pointer-wrap helper for non power-of-two buffers.
package pipe_result_collector_pkg;

  localparam logic MODE_BYPASS = 1'b0;
  localparam logic MODE_PIPED  = 1'b1;

  localparam int DEF_NUM_OF_PIPES = 32'sd3;
  localparam int DEF_NUM_OF_BITS  = 32'sd27;
  localparam int DEF_FIFO_DEPTH   = 32'sd8;

  // Advance a circular-buffer pointer, wrapping from depth-1 back to 0.
  function automatic int next_ptr(input int ptr, input int depth);
    if (ptr >= depth - 32'sd1) begin
      return 32'sd0;
    end else begin
      return ptr + 32'sd1;
    end
  endfunction

endpackage

// File: rtl/pipe_result_collector_if.sv
// Handshake bundle between the collector, its upstream issuer, the external
// delay line output and the downstream consumer.
interface pipe_result_collector_if
  import pipe_result_collector_pkg::*;
#(
  parameter int num_of_pipes = DEF_NUM_OF_PIPES,
  parameter int num_of_bits  = DEF_NUM_OF_BITS
) ();

  localparam int IFW = $clog2(num_of_pipes + 1);

  logic                   enable;
  logic                   issue_valid;
  logic                   issue_ready;
  logic [num_of_bits-1:0] pipe_data;
  logic [num_of_bits-1:0] out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [IFW-1:0]         in_flight;
  logic                   mode_err;

  modport master (
    output enable, issue_valid, pipe_data, out_ready,
    input  issue_ready, out_data, out_valid, in_flight, mode_err
  );

  modport slave (
    input  enable, issue_valid, pipe_data, out_ready,
    output issue_ready, out_data, out_valid, in_flight, mode_err
  );

endinterface

// File: rtl/pipe_result_collector_result_fifo.sv
// Circular result buffer with a registered head word. The head register is
// loaded with the word that will be at the front after this edge, so a pop
// presents the next word on the following cycle and a write into an empty
// buffer is visible one cycle after capture.
module result_fifo
  import pipe_result_collector_pkg::*;
#(
  parameter int depth = DEF_FIFO_DEPTH,
  parameter int width = DEF_NUM_OF_BITS,
  localparam int PW = $clog2(depth),
  localparam int CW = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [width-1:0] wr_data,
  input  logic             rd_en,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic [width-1:0] head,
  output logic             valid
);

  logic [width-1:0] mem_r [depth];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    rd_ptr_next_s;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_next_s;
  logic [width-1:0] head_r;
  logic [width-1:0] head_next_s;
  logic             valid_r;
  logic             push_s;
  logic             pop_s;

  assign full   = (count_r == CW'(depth));
  assign push_s = wr_en & ~full;
  assign pop_s  = rd_en & valid_r;

  // Next read pointer and next occupancy from this cycle's push/pop.
  always_comb begin
    rd_ptr_next_s = rd_ptr_r;
    count_next_s  = count_r;
    if (pop_s) begin
      rd_ptr_next_s = PW'(next_ptr(int'(rd_ptr_r), depth));
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + 1'b1;
      2'b01:   count_next_s = count_r - 1'b1;
      default: count_next_s = count_r;
    endcase
  end

  // Word that sits at the front after this edge; bypass the array when it is being written now.
  always_comb begin
    head_next_s = {width{1'b0}};
    if (count_next_s == {CW{1'b0}}) begin
      head_next_s = {width{1'b0}};
    end else if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
      head_next_s = wr_data;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // Storage array write.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy and registered head/valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      head_r   <= {width{1'b0}};
      valid_r  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= PW'(next_ptr(int'(wr_ptr_r), depth));
      end
      rd_ptr_r <= rd_ptr_next_s;
      count_r  <= count_next_s;
      head_r   <= head_next_s;
      valid_r  <= (count_next_s != {CW{1'b0}});
    end
  end

  assign count = count_r;
  assign head  = head_r;
  assign valid = valid_r;

endmodule

// File: rtl/pipe_result_collector.sv
// Consumer end of the selectable FC pipeline register: issues operands under
// credit control, tracks which delay-line slots carry live operands, captures
// the emerging words into the result FIFO and flags illegal mode switches.
module pipe_result_collector
  import pipe_result_collector_pkg::*;
#(
  parameter int num_of_pipes = DEF_NUM_OF_PIPES,
  parameter int num_of_bits  = DEF_NUM_OF_BITS,
  parameter int fifo_depth   = DEF_FIFO_DEPTH
) (
  input logic              clk_pll,
  input logic              reset,
  pipe_result_collector_if.slave bus
);

  localparam int IFW = $clog2(num_of_pipes + 1);
  localparam int CW  = $clog2(fifo_depth + 1);

  logic [num_of_pipes-1:0] trk_r;
  logic [num_of_pipes-1:0] trk_next_s;
  logic                    enable_q_r;
  logic                    mode_err_r;
  logic                    piped_s;
  logic                    accept_s;
  logic                    cap_s;
  logic                    mode_change_s;
  logic                    issue_ready_s;
  logic                    wr_en_s;
  logic                    fifo_full_s;
  logic [IFW-1:0]          in_flight_s;
  logic [CW-1:0]           count_s;
  logic [31:0]             credit_used_s;

  assign piped_s  = (bus.enable == MODE_PIPED);
  assign accept_s = bus.issue_valid & issue_ready_s;

  // Number of live operands in the delay line.
  always_comb begin
    in_flight_s = {IFW{1'b0}};
    for (int i = 0; i < num_of_pipes; i++) begin
      in_flight_s = in_flight_s + IFW'(trk_r[i]);
    end
  end

  // Credit counts stored words plus every slot still in flight; a same-cycle pop is ignored.
  assign credit_used_s = 32'(count_s) + 32'(in_flight_s);
  assign issue_ready_s = !reset && (credit_used_s < 32'(fifo_depth));

  assign mode_change_s = (bus.enable != enable_q_r) && (in_flight_s != {IFW{1'b0}});
  assign cap_s         = piped_s ? trk_r[num_of_pipes-1] : accept_s;
  assign wr_en_s       = cap_s & ~fifo_full_s;

  // Tracker shift: a mode switch kills older slots, but this cycle's issue follows the new mode.
  always_comb begin
    trk_next_s    = {num_of_pipes{1'b0}};
    trk_next_s[0] = accept_s & piped_s;
    for (int i = 1; i < num_of_pipes; i++) begin
      trk_next_s[i] = trk_r[i-1] & ~mode_change_s;
    end
  end

  // Tracker, previous mode and sticky error flag.
  always_ff @(posedge clk_pll) begin
    if (reset) begin
      trk_r      <= {num_of_pipes{1'b0}};
      enable_q_r <= MODE_BYPASS;
      mode_err_r <= 1'b0;
    end else begin
      trk_r      <= trk_next_s;
      enable_q_r <= bus.enable;
      if (mode_change_s || (cap_s && fifo_full_s)) begin
        mode_err_r <= 1'b1;
      end
    end
  end

  result_fifo #(
    .depth (fifo_depth),
    .width (num_of_bits)
  ) u_result_fifo (
    .clk     (clk_pll),
    .reset   (reset),
    .wr_en   (wr_en_s),
    .wr_data (bus.pipe_data),
    .rd_en   (bus.out_ready),
    .count   (count_s),
    .full    (fifo_full_s),
    .head    (bus.out_data),
    .valid   (bus.out_valid)
  );

  assign bus.issue_ready = issue_ready_s;
  assign bus.in_flight   = in_flight_s;
  assign bus.mode_err    = mode_err_r;

endmodule

// File: tb/tb_pipe_result_collector.sv
// Bench for pipe_result_collector: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model.
module tb_pipe_result_collector;

  localparam int N     = 3;
  localparam int W     = 27;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] issue_data = '0;
  logic [W-1:0] dl [N];

  pipe_result_collector_if #(.num_of_pipes(N), .num_of_bits(W)) bus ();

  pipe_result_collector #(
    .num_of_pipes (N),
    .num_of_bits  (W),
    .fifo_depth   (DEPTH)
  ) dut (
    .clk_pll (clk),
    .reset   (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // External delay line: shifts every cycle; bypass presents the input directly.
  always @(posedge clk) begin
    dl[0] <= issue_data;
    for (int i = 1; i < N; i++) dl[i] <= dl[i-1];
  end
  assign bus.pipe_data = bus.enable ? dl[N-1] : issue_data;

  // Reference model: words waiting in the delay line and words stored.
  typedef struct { int due; logic [W-1:0] data; } pend_t;
  pend_t        pend[$];
  logic [W-1:0] fq[$];
  bit           m_err;
  bit           m_enq;
  int           cyc;
  int           n_cmp;
  int           n_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs, advance the model.
  task automatic step(input bit rst_i, input bit en_i, input bit iv_i, input bit ordy_i,
                      input logic [W-1:0] d_i, output bit acc_o);
    bit           exp_rdy;
    bit           mchg;
    bit           cap;
    bit           full0;
    logic [W-1:0] cdata;
    logic [W-1:0] exp_head;
    @(negedge clk);
    rst             = rst_i;
    bus.enable      = en_i;
    bus.issue_valid = iv_i;
    bus.out_ready   = ordy_i;
    issue_data      = d_i;
    #1;
    exp_rdy  = !rst_i && ((fq.size() + pend.size()) < DEPTH);
    exp_head = (fq.size() != 0) ? fq[0] : '0;
    chk("issue_ready", 32'(bus.issue_ready), 32'(exp_rdy));
    chk("out_valid",   32'(bus.out_valid),   32'(fq.size() != 0));
    chk("out_data",    32'(bus.out_data),    32'(exp_head));
    chk("in_flight",   32'(bus.in_flight),   32'(pend.size()));
    chk("mode_err",    32'(bus.mode_err),    32'(m_err));
    acc_o = iv_i && exp_rdy;
    if (rst_i) begin
      fq.delete();
      pend.delete();
      m_err = 1'b0;
      m_enq = 1'b0;
    end else begin
      full0 = (fq.size() == DEPTH);
      mchg  = (en_i != m_enq) && (pend.size() != 0);
      if (mchg) begin
        m_err = 1'b1;
        pend.delete();
      end
      cap   = 1'b0;
      cdata = '0;
      if (en_i) begin
        if (pend.size() != 0 && pend[0].due == cyc) begin
          cap   = 1'b1;
          cdata = pend[0].data;
          void'(pend.pop_front());
        end
      end else if (acc_o) begin
        cap   = 1'b1;
        cdata = d_i;
      end
      if (fq.size() != 0 && ordy_i) void'(fq.pop_front());
      if (cap) begin
        if (full0) m_err = 1'b1;
        else fq.push_back(cdata);
      end
      if (en_i && acc_o) pend.push_back('{cyc + N, d_i});
      m_enq = en_i;
    end
    cyc++;
  endtask

  initial begin
    bit acc;
    int bp_n;
    bus.enable      = 1'b0;
    bus.issue_valid = 1'b0;
    bus.out_ready   = 1'b0;
    n_cmp = 0; n_mis = 0; cyc = 0; m_err = 1'b0; m_enq = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, '0, acc);

    // Delayed single issue
    repeat (4) step(1'b0, 1'b1, 1'b0, 1'b1, '0, acc);
    step(1'b0, 1'b1, 1'b1, 1'b1, 27'h1234567, acc);
    repeat (6) step(1'b0, 1'b1, 1'b0, 1'b1, '0, acc);

    // Backpressure to full, then drain in order
    bp_n = 0;
    repeat (16) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, W'(bp_n), acc);
      if (acc) bp_n++;
    end
    chk("bp_accepts", 32'(bp_n), 32'd8);
    repeat (12) step(1'b0, 1'b1, 1'b0, 1'b1, '0, acc);

    // Bypass streaming
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 1'b1, W'(32'h100 + i), acc);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, '0, acc);

    // Illegal mode change with two in flight, then a bypass issue
    step(1'b0, 1'b1, 1'b0, 1'b1, '0, acc);
    step(1'b0, 1'b1, 1'b1, 1'b1, 27'h0aaaaaa, acc);
    step(1'b0, 1'b1, 1'b1, 1'b1, 27'h0555555, acc);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0, acc);
    step(1'b0, 1'b0, 1'b1, 1'b1, 27'h7654321, acc);
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b1, '0, acc);

    // Mid-operation reset with words stored and in flight
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, acc);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, W'(32'h200 + i), acc);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, acc);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, acc);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, '0, acc);

    // Simultaneous capture and pop with four stored (bypass)
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, W'(32'h300 + i), acc);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, W'(32'h310 + i), acc);
    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b1, '0, acc);

    // Random traffic with occasional mode flips and resets
    begin
      bit en_r = 1'b1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 39) == 0) en_r = ~en_r;
        step(($urandom_range(0, 149) == 0), en_r, ($urandom_range(0, 9) < 7),
             ($urandom_range(0, 9) < 6), W'($urandom), acc);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
